// File: rtl/arm_multicycle_pkg.sv
// Shared types for the multicycle ARM core memory path: arbiter FSM states
// and the grant identifier used for round-robin sharing of the unified memory.
package arm_multicycle_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_ACCESS,
        STATE_RESP
    } arbStateType;

    typedef enum logic {
        GRANT_CPU,
        GRANT_DMA
    } grantType;

endpackage

// File: rtl/arm_multicycle_mem_arbiter.sv
// Two-requester (core / DMA) arbiter and wait-state sequencer for the unified
// instruction/data memory; retires each transaction with a one-cycle ready pulse.
module arm_multicycle_mem_arbiter
    import arm_multicycle_pkg::*;
#(
    parameter int BusWidth   = 32,
    parameter int WaitStates = 1
) (
    input  logic                i_CLK,
    input  logic                i_NRESET,
    input  logic                i_CPU_Req,
    input  logic                i_CPU_Write,
    input  logic [BusWidth-1:0] i_CPU_Addr,
    input  logic [BusWidth-1:0] i_CPU_WData,
    output logic [BusWidth-1:0] o_CPU_RData,
    output logic                o_CPU_Ready,
    input  logic                i_DMA_Req,
    input  logic                i_DMA_Write,
    input  logic [BusWidth-1:0] i_DMA_Addr,
    input  logic [BusWidth-1:0] i_DMA_WData,
    output logic [BusWidth-1:0] o_DMA_RData,
    output logic                o_DMA_Ready,
    output logic                o_Mem_En,
    output logic                o_Mem_WE,
    output logic [BusWidth-1:0] o_Mem_Addr,
    output logic [BusWidth-1:0] o_Mem_WData,
    input  logic [BusWidth-1:0] i_Mem_RData
);

    localparam int CntWidth = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;

    arbStateType          state_reg;
    grantType             grant_reg;
    logic                 write_reg;
    logic [CntWidth-1:0]  cnt_reg;
    logic                 mem_en_reg;
    logic                 mem_we_reg;
    logic [BusWidth-1:0]  mem_addr_reg;
    logic [BusWidth-1:0]  mem_wdata_reg;
    logic [BusWidth-1:0]  cpu_rdata_reg;
    logic [BusWidth-1:0]  dma_rdata_reg;
    logic                 cpu_ready_reg;
    logic                 dma_ready_reg;

    grantType             winner;
    logic                 sel_write;
    logic [BusWidth-1:0]  sel_addr;
    logic [BusWidth-1:0]  sel_wdata;

    // grant_reg doubles as the last-grant flop: on a tie the other side wins.
    always_comb begin
        winner    = (i_CPU_Req && (!i_DMA_Req || grant_reg == GRANT_DMA)) ? GRANT_CPU : GRANT_DMA;
        sel_write = (winner == GRANT_CPU) ? i_CPU_Write : i_DMA_Write;
        sel_addr  = (winner == GRANT_CPU) ? i_CPU_Addr  : i_DMA_Addr;
        sel_wdata = (winner == GRANT_CPU) ? i_CPU_WData : i_DMA_WData;
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            state_reg     <= STATE_IDLE;
            grant_reg     <= GRANT_DMA;
            write_reg     <= 1'b0;
            cnt_reg       <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_rdata_reg <= '0;
            dma_rdata_reg <= '0;
            cpu_ready_reg <= 1'b0;
            dma_ready_reg <= 1'b0;
        end else begin
            cpu_ready_reg <= 1'b0;
            dma_ready_reg <= 1'b0;
            case (state_reg)
                STATE_IDLE: begin
                    if (i_CPU_Req || i_DMA_Req) begin
                        grant_reg     <= winner;
                        write_reg     <= sel_write;
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_wdata;
                        cnt_reg       <= CntWidth'(WaitStates);
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= (WaitStates == 0) && sel_write;
                        state_reg     <= STATE_ACCESS;
                    end
                end
                STATE_ACCESS: begin
                    if (cnt_reg == '0) begin
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        if (!write_reg) begin
                            if (grant_reg == GRANT_CPU) cpu_rdata_reg <= i_Mem_RData;
                            else                        dma_rdata_reg <= i_Mem_RData;
                        end
                        cpu_ready_reg <= (grant_reg == GRANT_CPU);
                        dma_ready_reg <= (grant_reg == GRANT_DMA);
                        state_reg     <= STATE_RESP;
                    end else begin
                        cnt_reg    <= cnt_reg - 1'b1;
                        // Strobe lands only in the final access cycle.
                        mem_we_reg <= write_reg && (cnt_reg == CntWidth'(1));
                    end
                end
                STATE_RESP: state_reg <= STATE_IDLE;
                default:    state_reg <= STATE_IDLE;
            endcase
        end
    end

    assign o_Mem_En    = mem_en_reg;
    assign o_Mem_WE    = mem_we_reg;
    assign o_Mem_Addr  = mem_addr_reg;
    assign o_Mem_WData = mem_wdata_reg;
    assign o_CPU_RData = cpu_rdata_reg;
    assign o_DMA_RData = dma_rdata_reg;
    assign o_CPU_Ready = cpu_ready_reg;
    assign o_DMA_Ready = dma_ready_reg;

endmodule

// File: tb/tb_arm_multicycle_mem_arbiter.sv
// Bench for the memory arbiter: one instance per WaitStates value 0..3, each with
// its own word-addressed memory model; table-driven arbitration plus timing sequences.
module tb_arm_multicycle_mem_arbiter;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        nreset, cpu_req, cpu_write, dma_req, dma_write;
    logic [NI-1:0][31:0]  cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    wire  [NI-1:0][31:0]  cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    wire  [NI-1:0]        cpu_ready, dma_ready, mem_en, mem_we;
    logic                 mem_init;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            logic [31:0] mem [16];
            int          both_cnt = 0;

            arm_multicycle_mem_arbiter #(.BusWidth(32), .WaitStates(gi)) u_dut (
                .i_CLK       (clk),
                .i_NRESET    (nreset[gi]),
                .i_CPU_Req   (cpu_req[gi]),
                .i_CPU_Write (cpu_write[gi]),
                .i_CPU_Addr  (cpu_addr[gi]),
                .i_CPU_WData (cpu_wdata[gi]),
                .o_CPU_RData (cpu_rdata[gi]),
                .o_CPU_Ready (cpu_ready[gi]),
                .i_DMA_Req   (dma_req[gi]),
                .i_DMA_Write (dma_write[gi]),
                .i_DMA_Addr  (dma_addr[gi]),
                .i_DMA_WData (dma_wdata[gi]),
                .o_DMA_RData (dma_rdata[gi]),
                .o_DMA_Ready (dma_ready[gi]),
                .o_Mem_En    (mem_en[gi]),
                .o_Mem_WE    (mem_we[gi]),
                .o_Mem_Addr  (mem_addr[gi]),
                .o_Mem_WData (mem_wdata[gi]),
                .i_Mem_RData (mem_rdata[gi])
            );

            assign mem_rdata[gi] = mem[mem_addr[gi][5:2]];

            always @(posedge clk) begin
                if (mem_init) begin
                    for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
                end else if (mem_en[gi] && mem_we[gi]) begin
                    mem[mem_addr[gi][5:2]] <= mem_wdata[gi];
                end
            end

            always @(negedge clk) begin
                if (cpu_ready[gi] && dma_ready[gi]) both_cnt <= both_cnt + 1;
            end
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic set_cpu(input int k, input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_req[k] = req; cpu_write[k] = wr; cpu_addr[k] = a; cpu_wdata[k] = d;
    endtask

    task automatic set_dma(input int k, input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        dma_req[k] = req; dma_write[k] = wr; dma_addr[k] = a; dma_wdata[k] = d;
    endtask

    // Latency counted in falling edges after the inputs were set; 0 means timeout.
    task automatic wait_ready(input int k, input int budget, output int lat, output logic gc, output logic gd);
        lat = 0; gc = 1'b0; gd = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (cpu_ready[k] || dma_ready[k]) begin
                lat = i; gc = cpu_ready[k]; gd = dma_ready[k];
                break;
            end
        end
    endtask

    typedef struct {
        logic        cr; logic cw; logic [31:0] ca; logic [31:0] cd;
        logic        dr; logic dw; logic [31:0] da; logic [31:0] dd;
        logic        ec; logic ed; int lat;
        logic [31:0] ecr; logic [31:0] edr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        gc, gd;
        logic [7:0]  en_tr, rdy_tr, we_tr;
        logic [31:0] addr_c1;
        int          ev_c [8];
        int          ev_w [8];
        int          n_ev, ncpu, ndma, bad;
        int          exp_c [5];
        int          exp_w [5];

        tbl[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 3, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h4,  32'h0,        1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 4, 32'hDEADBEEF, 32'hA5A50002};
        tbl[2] = '{1'b1, 1'b0, 32'h4,  32'h0,        1'b1, 1'b1, 32'h0, 32'h12345678, 1'b1, 1'b0, 4, 32'hA5A50001, 32'hA5A50002};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b1, 4, 32'hA5A50001, 32'hA5A50002};
        tbl[4] = '{1'b1, 1'b1, 32'h8,  32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 4, 32'hA5A50001, 32'hA5A50002};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 4, 32'hA5A50001, 32'h12345678};
        tbl[6] = '{1'b1, 1'b0, 32'h8,  32'h0,        1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 4, 32'hCAFEF00D, 32'h12345678};
        tbl[7] = '{1'b1, 1'b0, 32'hC,  32'h0,        1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 4, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[8] = '{1'b1, 1'b0, 32'hC,  32'h0,        1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 4, 32'hA5A50003, 32'hCAFEF00D};

        nreset = '0; cpu_req = '0; cpu_write = '0; dma_req = '0; dma_write = '0;
        cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
        mem_init = 1'b1;
        // Instance 2 requests on both ports straight out of reset.
        set_cpu(2, 1'b1, 1'b0, 32'h14, 32'h0);
        set_dma(2, 1'b1, 1'b0, 32'h18, 32'h0);
        repeat (2) @(negedge clk);
        mem_init = 1'b0;

        for (int k = 0; k < NI; k += 3) begin
            check($sformatf("reset[%0d] en", k),     32'(mem_en[k]),    32'h0);
            check($sformatf("reset[%0d] we", k),     32'(mem_we[k]),    32'h0);
            check($sformatf("reset[%0d] ready", k),  32'({cpu_ready[k], dma_ready[k]}), 32'h0);
            check($sformatf("reset[%0d] addr", k),   mem_addr[k],       32'h0);
            check($sformatf("reset[%0d] wdata", k),  mem_wdata[k],      32'h0);
            check($sformatf("reset[%0d] cpu_rd", k), cpu_rdata[k],      32'h0);
            check($sformatf("reset[%0d] dma_rd", k), dma_rdata[k],      32'h0);
        end
        nreset = '1;

        // Both requesters held from reset, WaitStates=2: alternate CPU first, period 5.
        n_ev = 0; ncpu = 0; ndma = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (cpu_ready[2]) begin
                if (n_ev < 8) begin ev_c[n_ev] = c; ev_w[n_ev] = 0; end
                n_ev++; ncpu++;
                if (ncpu == 3) cpu_req[2] = 1'b0;
            end
            if (dma_ready[2]) begin
                if (n_ev < 8) begin ev_c[n_ev] = c; ev_w[n_ev] = 1; end
                n_ev++; ndma++;
                if (ndma == 2) dma_req[2] = 1'b0;
            end
        end
        exp_c = '{4, 9, 14, 19, 24};
        exp_w = '{0, 1, 0, 1, 0};
        check("rr event count", 32'(n_ev), 32'd5);
        for (int i = 0; i < 5 && i < n_ev; i++) begin
            check($sformatf("rr ev%0d cycle", i), 32'(ev_c[i]), 32'(exp_c[i]));
            check($sformatf("rr ev%0d who", i),   32'(ev_w[i]), 32'(exp_w[i]));
        end
        check("rr cpu_rd", cpu_rdata[2], 32'hA5A50005);
        check("rr dma_rd", dma_rdata[2], 32'hA5A50006);
        $display("seq rr: %0d ready events", n_ev);

        // Reset during the first ACCESS cycle of a write, WaitStates=2.
        set_cpu(2, 1'b1, 1'b1, 32'h1C, 32'hBADC0DE5);
        @(negedge clk);
        check("abort en c1", 32'(mem_en[2]), 32'h1);
        nreset[2] = 1'b0;
        set_cpu(2, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("abort async en",     32'(mem_en[2]), 32'h0);
        check("abort async we",     32'(mem_we[2]), 32'h0);
        check("abort async addr",   mem_addr[2],    32'h0);
        check("abort async wdata",  mem_wdata[2],   32'h0);
        check("abort async cpu_rd", cpu_rdata[2],   32'h0);
        check("abort async dma_rd", dma_rdata[2],   32'h0);
        @(negedge clk);
        nreset[2] = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_en[2] || mem_we[2] || cpu_ready[2] || dma_ready[2]) bad++;
        end
        check("abort quiet cycles", 32'(bad), 32'h0);
        check("abort mem unchanged", g_dut[2].mem[7], 32'hA5A50007);
        $display("seq abort: quiet violations %0d", bad);

        // Core read, WaitStates=1: En in cycles 1-2, Ready in cycle 3.
        en_tr = '0; rdy_tr = '0; we_tr = '0;
        set_cpu(1, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            en_tr[c-1] = mem_en[1]; rdy_tr[c-1] = cpu_ready[1] | dma_ready[1]; we_tr[c-1] = mem_we[1];
        end
        set_cpu(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("ws1 read en trace",    32'(en_tr),  32'h3);
        check("ws1 read ready trace", 32'(rdy_tr), 32'h4);
        check("ws1 read we trace",    32'(we_tr),  32'h0);
        check("ws1 read cpu_rd",      cpu_rdata[1], 32'hDEADBEEF);
        check("ws1 read addr held",   mem_addr[1],  32'h10);
        $display("seq ws1 read: en=%b ready=%b", en_tr[2:0], rdy_tr[2:0]);
        @(negedge clk);

        // Table-driven back-to-back transactions, WaitStates=1.
        for (int r = 0; r < 9; r++) begin
            set_cpu(1, tbl[r].cr, tbl[r].cw, tbl[r].ca, tbl[r].cd);
            set_dma(1, tbl[r].dr, tbl[r].dw, tbl[r].da, tbl[r].dd);
            wait_ready(1, 10, lat, gc, gd);
            check($sformatf("row%0d latency", r),   32'(lat), 32'(tbl[r].lat));
            check($sformatf("row%0d cpu_ready", r), 32'(gc),  32'(tbl[r].ec));
            check($sformatf("row%0d dma_ready", r), 32'(gd),  32'(tbl[r].ed));
            check($sformatf("row%0d cpu_rd", r),    cpu_rdata[1], tbl[r].ecr);
            check($sformatf("row%0d dma_rd", r),    dma_rdata[1], tbl[r].edr);
            $display("row %0d: lat=%0d cpu=%0b dma=%0b cpu_rd=%08h dma_rd=%08h", r, lat, gc, gd, cpu_rdata[1], dma_rdata[1]);
        end
        set_cpu(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Core write, WaitStates=0: WE only in cycle 1, Ready in cycle 2.
        en_tr = '0; rdy_tr = '0; we_tr = '0; addr_c1 = '0;
        set_cpu(0, 1'b1, 1'b1, 32'h20, 32'h0000CAFE);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            we_tr[c-1] = mem_we[0]; rdy_tr[c-1] = cpu_ready[0];
            if (c == 1) addr_c1 = mem_addr[0];
        end
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("ws0 write we trace",    32'(we_tr),  32'h1);
        check("ws0 write ready trace", 32'(rdy_tr), 32'h2);
        check("ws0 write addr c1",     addr_c1,      32'h20);
        check("ws0 write dma_rd",      dma_rdata[0], 32'h0);
        check("ws0 write mem",         g_dut[0].mem[8], 32'h0000CAFE);
        $display("seq ws0 write: we=%b ready=%b", we_tr[1:0], rdy_tr[1:0]);

        // DMA alone, four back-to-back reads, WaitStates=0.
        for (int i = 0; i < 4; i++) begin
            set_dma(0, 1'b1, 1'b0, 32'(4 * i), 32'h0);
            wait_ready(0, 8, lat, gc, gd);
            check($sformatf("dma%0d latency", i), 32'(lat), 32'd3);
            check($sformatf("dma%0d who", i),     32'({gc, gd}), 32'h1);
            check($sformatf("dma%0d rdata", i),   dma_rdata[0], 32'hA5A5_0000 + 32'(i));
            $display("dma read %0d: lat=%0d rdata=%08h", i, lat, dma_rdata[0]);
        end
        set_dma(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("dma seq cpu_rd", cpu_rdata[0], 32'h0);

        // WaitStates=3, core drops Req mid-ACCESS: still retires at cycle 5.
        en_tr = '0; rdy_tr = '0;
        set_cpu(3, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            en_tr[c-1] = mem_en[3]; rdy_tr[c-1] = cpu_ready[3] | dma_ready[3];
            if (c == 2) set_cpu(3, 1'b0, 1'b0, 32'h10, 32'h0);
        end
        check("ws3 drop en trace",    32'(en_tr),  32'h0F);
        check("ws3 drop ready trace", 32'(rdy_tr), 32'h10);
        check("ws3 drop cpu_rd",      cpu_rdata[3], 32'hDEADBEEF);
        $display("seq ws3 drop: en=%b ready=%b", en_tr[6:0], rdy_tr[6:0]);

        check("both ready ws0", 32'(g_dut[0].both_cnt), 32'h0);
        check("both ready ws1", 32'(g_dut[1].both_cnt), 32'h0);
        check("both ready ws2", 32'(g_dut[2].both_cnt), 32'h0);
        check("both ready ws3", 32'(g_dut[3].both_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
